// File: rtl/sr_cmd_pkg.sv
// Shared constants, FSM state encoding and sizing helper for the SR command conditioner.
package sr_cmd_pkg;

    localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;
    localparam int unsigned DEF_PULSE_CYCLES    = 2;

    typedef logic [1:0] sr_state_t;

    localparam sr_state_t IDLE    = 2'b00;
    localparam sr_state_t DRIVE_S = 2'b01;
    localparam sr_state_t DRIVE_R = 2'b10;
    localparam sr_state_t GAP     = 2'b11;

    // Bits needed to hold values 0..max_count.
    function automatic int unsigned cnt_width(input int unsigned max_count);
        return (max_count < 1) ? 1 : $clog2(max_count + 1);
    endfunction

endpackage

// File: rtl/sr_cmd_conditioner_if.sv
// Button inputs and clean latch-drive outputs of the SR command conditioner.
interface sr_cmd_conditioner_if;

    logic set_btn;
    logic reset_btn;
    logic enable_btn;
    logic s_out;
    logic r_out;
    logic e_out;
    logic q_model;
    logic conflict;
    logic dropped;
    logic busy;

    modport master (
        output set_btn,
        output reset_btn,
        output enable_btn,
        input  s_out,
        input  r_out,
        input  e_out,
        input  q_model,
        input  conflict,
        input  dropped,
        input  busy
    );

    modport slave (
        input  set_btn,
        input  reset_btn,
        input  enable_btn,
        output s_out,
        output r_out,
        output e_out,
        output q_model,
        output conflict,
        output dropped,
        output busy
    );

endinterface

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, stable-sample debounce and optional
// registered rising-edge pulse.
module debounce_channel
    import sr_cmd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter bit          EDGE_EN         = 1'b1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          deb_q;
    logic          deb_d;
    logic          deb_prev_q;
    logic          rise_q;
    logic          rise_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        // Any sample agreeing with the accepted level restarts the count.
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = ~deb_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        rise_d = EDGE_EN ? (deb_q & ~deb_prev_q) : 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            rise_q     <= 1'b0;
            cnt_q      <= '0;
        end else begin
            sync1_q    <= btn_i;
            sync2_q    <= sync1_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            rise_q     <= rise_d;
            cnt_q      <= cnt_d;
        end
    end

    assign level_o = deb_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/sr_cmd_conditioner.sv
// Turns bouncy set/reset/enable buttons into mutually exclusive s/r pulses and a
// steady enable level, tracking the expected latch state.
module sr_cmd_conditioner
    import sr_cmd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int unsigned PULSE_CYCLES    = DEF_PULSE_CYCLES,
    parameter bit          RESET_WINS      = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sr_cmd_conditioner_if.slave  bus
);

    localparam int unsigned PW = cnt_width(PULSE_CYCLES);
    localparam logic [PW-1:0] PCNT_LAST = PW'(PULSE_CYCLES - 1);

    logic set_lvl_unused;
    logic reset_lvl_unused;
    logic en_rise_unused;
    logic set_req;
    logic reset_req;
    logic en_lvl;

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .EDGE_EN         (1'b1)
    ) u_set_ch (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (bus.set_btn),
        .level_o (set_lvl_unused),
        .rise_o  (set_req)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .EDGE_EN         (1'b1)
    ) u_reset_ch (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (bus.reset_btn),
        .level_o (reset_lvl_unused),
        .rise_o  (reset_req)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .EDGE_EN         (1'b0)
    ) u_en_ch (
        .clk     (clk),
        .rst_n   (rst_n),
        .btn_i   (bus.enable_btn),
        .level_o (en_lvl),
        .rise_o  (en_rise_unused)
    );

    sr_state_t     state_q;
    sr_state_t     state_d;
    logic [PW-1:0] pcnt_q;
    logic [PW-1:0] pcnt_d;
    logic          set_pend_q;
    logic          set_pend_d;
    logic          reset_pend_q;
    logic          reset_pend_d;
    logic          q_model_q;
    logic          q_model_d;
    logic          s_out_q;
    logic          s_out_d;
    logic          r_out_q;
    logic          r_out_d;
    logic          conflict_q;
    logic          conflict_d;
    logic          dropped_q;
    logic          dropped_d;
    logic          busy_q;
    logic          busy_d;
    logic          cand_s;
    logic          cand_r;

    always_comb begin
        state_d      = state_q;
        pcnt_d       = pcnt_q;
        set_pend_d   = set_pend_q;
        reset_pend_d = reset_pend_q;
        q_model_d    = q_model_q;
        conflict_d   = 1'b0;
        dropped_d    = 1'b0;
        cand_s       = 1'b0;
        cand_r       = 1'b0;

        unique case (state_q)
            IDLE: begin
                cand_s       = set_req | set_pend_q;
                cand_r       = reset_req | reset_pend_q;
                // Every candidate is consumed here: served, lost a conflict, or dropped.
                set_pend_d   = 1'b0;
                reset_pend_d = 1'b0;
                pcnt_d       = '0;
                if (cand_s && cand_r) begin
                    conflict_d = 1'b1;
                    if (RESET_WINS) begin
                        cand_s = 1'b0;
                    end else begin
                        cand_r = 1'b0;
                    end
                end
                if (cand_s || cand_r) begin
                    if (!en_lvl) begin
                        dropped_d = 1'b1;
                    end else begin
                        state_d = cand_s ? DRIVE_S : DRIVE_R;
                    end
                end
            end
            DRIVE_S, DRIVE_R: begin
                set_pend_d   = set_pend_q | set_req;
                reset_pend_d = reset_pend_q | reset_req;
                if (!en_lvl) begin
                    state_d   = GAP;
                    dropped_d = 1'b1;
                end else if (pcnt_q == PCNT_LAST) begin
                    state_d   = GAP;
                    q_model_d = (state_q == DRIVE_S);
                end else begin
                    pcnt_d = pcnt_q + 1'b1;
                end
            end
            GAP: begin
                set_pend_d   = set_pend_q | set_req;
                reset_pend_d = reset_pend_q | reset_req;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase

        s_out_d = (state_d == DRIVE_S);
        r_out_d = (state_d == DRIVE_R);
        busy_d  = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pcnt_q       <= '0;
            set_pend_q   <= 1'b0;
            reset_pend_q <= 1'b0;
            q_model_q    <= 1'b0;
            s_out_q      <= 1'b0;
            r_out_q      <= 1'b0;
            conflict_q   <= 1'b0;
            dropped_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            pcnt_q       <= pcnt_d;
            set_pend_q   <= set_pend_d;
            reset_pend_q <= reset_pend_d;
            q_model_q    <= q_model_d;
            s_out_q      <= s_out_d;
            r_out_q      <= r_out_d;
            conflict_q   <= conflict_d;
            dropped_q    <= dropped_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.s_out    = s_out_q;
    assign bus.r_out    = r_out_q;
    assign bus.e_out    = en_lvl;
    assign bus.q_model  = q_model_q;
    assign bus.conflict = conflict_q;
    assign bus.dropped  = dropped_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_sr_cmd_conditioner.sv
// Directed scenarios plus random bouncy buttons on two conditioners (reset-wins and
// set-wins), every cycle compared against a behavioural model.
module tb_sr_cmd_conditioner;
    import sr_cmd_pkg::*;

    localparam int unsigned DB = 4;
    localparam int unsigned PC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic set_btn = 1'b0;
    logic reset_btn = 1'b0;
    logic enable_btn = 1'b0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sr_cmd_conditioner_if bus_a ();
    sr_cmd_conditioner_if bus_b ();

    assign bus_a.set_btn    = set_btn;
    assign bus_a.reset_btn  = reset_btn;
    assign bus_a.enable_btn = enable_btn;
    assign bus_b.set_btn    = set_btn;
    assign bus_b.reset_btn  = reset_btn;
    assign bus_b.enable_btn = enable_btn;

    sr_cmd_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .PULSE_CYCLES    (PC),
        .RESET_WINS      (1'b1)
    ) u_dut_rw1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    sr_cmd_conditioner #(
        .DEBOUNCE_CYCLES (DB),
        .PULSE_CYCLES    (PC),
        .RESET_WINS      (1'b0)
    ) u_dut_rw0 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    task automatic check_eq(input string tag, input logic got, input logic exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    // Channel model: button samples newest first, accepted level at the last two edges.
    bit hist [3][DB+1];
    bit deb_m [3];
    bit deb_p [3];
    bit req_m [3];

    // Command model, index 0 = reset wins, 1 = set wins. phase: 0 idle, 1 driving, 2 gap.
    int phase [2];
    int elapsed [2];
    bit drv_set [2];
    bit spend [2];
    bit rpend [2];
    bit q_m [2];
    bit conf_m [2];
    bit drop_m [2];

    function automatic bit btn_val(input int c);
        return (c == 0) ? set_btn : ((c == 1) ? reset_btn : enable_btn);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i <= DB; i++) hist[c][i] = 1'b0;
            deb_m[c] = 1'b0;
            deb_p[c] = 1'b0;
            req_m[c] = 1'b0;
        end
        for (int d = 0; d < 2; d++) begin
            phase[d] = 0; elapsed[d] = 0; drv_set[d] = 1'b0;
            spend[d] = 1'b0; rpend[d] = 1'b0; q_m[d] = 1'b0;
            conf_m[d] = 1'b0; drop_m[d] = 1'b0;
        end
    endtask

    task automatic model_step();
        bit req_prev [3];
        bit e_prev;
        bit flip;
        bit cs;
        bit cr;
        e_prev = deb_m[2];
        for (int c = 0; c < 3; c++) begin
            req_prev[c] = req_m[c];
            // Accepted level flips once DB consecutive synced samples disagree with it.
            flip = 1'b1;
            for (int i = 1; i <= DB; i++) if (hist[c][i] == deb_m[c]) flip = 1'b0;
            req_m[c] = deb_m[c] & ~deb_p[c];
            deb_p[c] = deb_m[c];
            if (flip) deb_m[c] = ~deb_m[c];
            for (int i = DB; i >= 1; i--) hist[c][i] = hist[c][i-1];
            hist[c][0] = btn_val(c);
        end
        for (int d = 0; d < 2; d++) begin
            conf_m[d] = 1'b0;
            drop_m[d] = 1'b0;
            if (phase[d] == 0) begin
                cs = req_prev[0] | spend[d];
                cr = req_prev[1] | rpend[d];
                spend[d] = 1'b0;
                rpend[d] = 1'b0;
                if (cs && cr) begin
                    conf_m[d] = 1'b1;
                    if (d == 0) cs = 1'b0; else cr = 1'b0;
                end
                if (cs || cr) begin
                    if (!e_prev) drop_m[d] = 1'b1;
                    else begin
                        phase[d] = 1; drv_set[d] = cs; elapsed[d] = 1;
                    end
                end
            end else begin
                spend[d] |= req_prev[0];
                rpend[d] |= req_prev[1];
                if (phase[d] == 2) phase[d] = 0;
                else if (!e_prev) begin
                    drop_m[d] = 1'b1; phase[d] = 2;
                end else if (elapsed[d] == int'(PC)) begin
                    q_m[d] = drv_set[d]; phase[d] = 2;
                end else elapsed[d]++;
            end
        end
    endtask

    task automatic compare_one(input int d, input logic s, input logic r, input logic e,
                               input logic q, input logic cf, input logic dr, input logic b);
        string p;
        p = (d == 0) ? "rw1" : "rw0";
        check_eq({p, ".s_out"}, s, (phase[d] == 1) && drv_set[d]);
        check_eq({p, ".r_out"}, r, (phase[d] == 1) && !drv_set[d]);
        check_eq({p, ".e_out"}, e, deb_m[2]);
        check_eq({p, ".q_model"}, q, q_m[d]);
        check_eq({p, ".conflict"}, cf, conf_m[d]);
        check_eq({p, ".dropped"}, dr, drop_m[d]);
        check_eq({p, ".busy"}, b, phase[d] != 0);
        check_eq({p, ".s_and_r"}, s & r, 1'b0);
    endtask

    task automatic compare_all();
        compare_one(0, bus_a.s_out, bus_a.r_out, bus_a.e_out, bus_a.q_model,
                    bus_a.conflict, bus_a.dropped, bus_a.busy);
        compare_one(1, bus_b.s_out, bus_b.r_out, bus_b.e_out, bus_b.q_model,
                    bus_b.conflict, bus_b.dropped, bus_b.busy);
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic drive(input logic s, input logic r, input logic e, input int n);
        set_btn = s;
        reset_btn = r;
        enable_btn = e;
        repeat (n) cycle();
    endtask

    int  hold [3];
    bit  reached;

    initial begin
        model_reset();
        #1;
        compare_all();
        repeat (3) cycle();
        rst_n = 1'b1;

        // Clean set with enable settled high.
        drive(1'b0, 1'b0, 1'b1, 12);
        drive(1'b1, 1'b0, 1'b1, 20);
        drive(1'b0, 1'b0, 1'b1, 12);

        // Bounce train settling low, then settling high.
        for (int i = 0; i < 6; i++) drive(i % 2 == 0, 1'b0, 1'b1, 1);
        drive(1'b0, 1'b0, 1'b1, 14);
        for (int i = 0; i < 6; i++) drive(i % 2 == 0, 1'b0, 1'b1, 1);
        drive(1'b1, 1'b0, 1'b1, 16);
        drive(1'b0, 1'b0, 1'b1, 12);

        // Simultaneous set and reset.
        drive(1'b1, 1'b1, 1'b1, 16);
        drive(1'b0, 1'b0, 1'b1, 12);

        // Gated off, then a late enable rise.
        drive(1'b0, 1'b0, 1'b0, 12);
        drive(1'b1, 1'b0, 1'b0, 14);
        drive(1'b1, 1'b0, 1'b1, 14);
        drive(1'b0, 1'b0, 1'b1, 12);

        // Reset request arriving while set is being driven.
        drive(1'b1, 1'b0, 1'b1, 8);
        drive(1'b1, 1'b1, 1'b1, 20);
        drive(1'b0, 1'b0, 1'b1, 12);

        // Asynchronous reset during the first s_out cycle.
        set_btn = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 30 && !reached; i++) begin
            cycle();
            reached = (phase[1] == 1) && drv_set[1];
        end
        check_eq("mid_op_reached", reached, 1'b1);
        rst_n = 1'b0;
        set_btn = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (3) cycle();
        rst_n = 1'b1;
        drive(1'b0, 1'b0, 1'b1, 16);

        // Random bouncy buttons; enable mostly high.
        for (int c = 0; c < 3; c++) hold[c] = 0;
        for (int n = 0; n < 3000; n++) begin
            for (int c = 0; c < 3; c++) begin
                if (hold[c] == 0) begin
                    hold[c] = ($urandom_range(0, 5) == 0) ? 1 : int'($urandom_range(2, 16));
                    if (c == 0) set_btn = $urandom_range(0, 1) == 1;
                    else if (c == 1) reset_btn = $urandom_range(0, 1) == 1;
                    else enable_btn = $urandom_range(0, 9) < 8;
                end
                hold[c]--;
            end
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
